config_loader: RTL and testbench

//   Loads the configuration of a row of N_TILES logic tiles from a word-wide bitstream.

---
 rtl/config_loader.sv | 161 ++++++++++++++++
 tb/tb_config_loader.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/config_loader.sv
// config_loader: receives a word-wide bitstream and checks its XOR checksum. A good
// stream is committed atomically to the tile config buses, then the fabric leaves reset.

module config_loader_slice #(
    parameter int CONFIG_WIDTH = 29
) (
    input  logic                    clock,
    input  logic                    nreset,
    input  logic                    commit_i,
    input  logic [CONFIG_WIDTH-1:0] shadow_i,
    output logic [CONFIG_WIDTH-1:0] cfg_o
);
    logic [CONFIG_WIDTH-1:0] cfg_q;

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset)       cfg_q <= '0;
        else if (commit_i) cfg_q <= shadow_i;
    end

    assign cfg_o = cfg_q;
endmodule

module config_loader #(
    parameter int CONFIG_WIDTH = 29,
    parameter int N_TILES      = 4,
    parameter int WORD_WIDTH   = 8
) (
    input  logic                            clock,
    input  logic                            nreset,
    input  logic                            start,
    input  logic [WORD_WIDTH-1:0]           in_data,
    input  logic                            in_valid,
    output logic                            in_ready,
    output logic [N_TILES*CONFIG_WIDTH-1:0] config_out,
    output logic                            fabric_nreset,
    output logic                            fabric_enable,
    output logic                            busy,
    output logic                            done,
    output logic                            error
);
    localparam int T     = N_TILES * CONFIG_WIDTH;
    localparam int W     = (T + WORD_WIDTH - 1) / WORD_WIDTH;
    localparam int SH_W  = W * WORD_WIDTH;
    localparam int CNT_W = $clog2(W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(W - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CHECK, RELEASE, RUN, ERROR} state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic done;
        logic error;
        logic fab_nrst;
        logic fab_en;
    } outs_t;

    // Outputs are loaded together with the state they belong to, so they stay glitch-free.
    function automatic outs_t decode(input state_t s);
        outs_t o;
        o = '0;
        case (s)
            LOAD, CHECK: begin o.in_ready = 1'b1; o.busy = 1'b1; end
            RELEASE:     o.fab_nrst = 1'b1;
            RUN:         begin o.fab_nrst = 1'b1; o.fab_en = 1'b1; o.done = 1'b1; end
            ERROR:       o.error = 1'b1;
            default:     o = '0;
        endcase
        return o;
    endfunction

    state_t                state_q;
    outs_t                 outs_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [WORD_WIDTH-1:0] acc_q;
    logic [SH_W-1:0]       shadow_q;
    logic                  xfer;
    logic                  commit_d;

    assign xfer     = in_valid && outs_q.in_ready;
    assign commit_d = (state_q == CHECK) && xfer && (in_data == acc_q);

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            outs_q  <= '0;
            cnt_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE, RUN, ERROR: begin
                    if (start) begin
                        state_q <= LOAD;
                        outs_q  <= decode(LOAD);
                        cnt_q   <= '0;
                        acc_q   <= '0;
                    end
                end
                LOAD: begin
                    if (xfer) begin
                        acc_q <= acc_q ^ in_data;
                        cnt_q <= cnt_q + 1'b1;
                        if (cnt_q == LAST) begin
                            state_q <= CHECK;
                            outs_q  <= decode(CHECK);
                        end
                    end
                end
                CHECK: begin
                    if (xfer) begin
                        if (in_data == acc_q) begin
                            state_q <= RELEASE;
                            outs_q  <= decode(RELEASE);
                        end else begin
                            state_q <= ERROR;
                            outs_q  <= decode(ERROR);
                        end
                    end
                end
                RELEASE: begin
                    state_q <= RUN;
                    outs_q  <= decode(RUN);
                end
                default: begin
                    state_q <= IDLE;
                    outs_q  <= decode(IDLE);
                end
            endcase
        end
    end

    // Shadow is always fully rewritten before a commit, so it carries no reset.
    always_ff @(posedge clock) begin
        if (state_q == LOAD && xfer)
            shadow_q[cnt_q*WORD_WIDTH +: WORD_WIDTH] <= in_data;
    end

    generate
        if (SH_W > T) begin : g_pad
            logic unused_pad;
            assign unused_pad = ^shadow_q[SH_W-1:T];
        end
    endgenerate

    for (genvar t = 0; t < N_TILES; t++) begin : g_tile
        config_loader_slice #(.CONFIG_WIDTH(CONFIG_WIDTH)) u_slice (
            .clock    (clock),
            .nreset   (nreset),
            .commit_i (commit_d),
            .shadow_i (shadow_q[t*CONFIG_WIDTH +: CONFIG_WIDTH]),
            .cfg_o    (config_out[t*CONFIG_WIDTH +: CONFIG_WIDTH])
        );
    end

    assign in_ready      = outs_q.in_ready;
    assign busy          = outs_q.busy;
    assign done          = outs_q.done;
    assign error         = outs_q.error;
    assign fabric_nreset = outs_q.fab_nrst;
    assign fabric_enable = outs_q.fab_en;
endmodule

// File: tb/tb_config_loader.sv
// Randomized bench for config_loader (1 tile, 29 config bits, 8-bit words, 4 payload words).
module tb_config_loader;
    localparam int CW = 29;
    localparam int WW = 8;
    localparam int NW = 4;

    logic          clock = 0;
    logic          nreset = 0;
    logic          start = 0;
    logic [WW-1:0] in_data = '0;
    logic          in_valid = 0;
    logic          in_ready;
    logic [CW-1:0] config_out;
    logic          fabric_nreset, fabric_enable, busy, done, error;

    int n_tests = 0;
    int n_fail  = 0;
    logic [CW-1:0] exp_cfg = '0;
    bit tog_ph = 0;

    config_loader #(.CONFIG_WIDTH(CW), .N_TILES(1), .WORD_WIDTH(WW)) dut (
        .clock(clock), .nreset(nreset), .start(start), .in_data(in_data),
        .in_valid(in_valid), .in_ready(in_ready), .config_out(config_out),
        .fabric_nreset(fabric_nreset), .fabric_enable(fabric_enable),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Present one word until the handshake consumes it.
    task automatic push(input logic [WW-1:0] w, input bit toggle, input bit pulse_start);
        bit sent = 0;
        int guard = 0;
        in_data = w;
        while (!sent && guard < 20) begin
            if (toggle) begin
                in_valid = tog_ph;
                tog_ph = ~tog_ph;
            end else begin
                in_valid = 1'b1;
            end
            start = pulse_start && (guard == 0);
            sent = in_valid && in_ready;
            tick();
            guard++;
        end
        start = 0;
        if (!sent) chk("push_timeout", 0, 1);
    endtask

    // Full stream: model decides the expected outcome from the words alone.
    task automatic load(input logic [WW-1:0] w[NW], input logic [WW-1:0] csum,
                        input bit toggle, input bit mid_start, input bit extra_valid);
        logic [WW-1:0] x = '0;
        longint unsigned img = 0;
        bit good;
        for (int k = 0; k < NW; k++) begin
            x = x ^ w[k];
            img = img + (longint'(w[k]) << (WW * k));
        end
        good = (csum == x);
        in_valid = extra_valid;
        in_data  = 8'h5A;
        start = 1;
        tick();
        start = 0;
        chk("load_busy", busy, 1);
        chk("load_ready", in_ready, 1);
        chk("load_fnrst", fabric_nreset, 0);
        chk("load_fen", fabric_enable, 0);
        for (int k = 0; k < NW; k++) push(w[k], toggle, mid_start && k == 1);
        chk("check_busy", busy, 1);
        chk("cfg_hold", config_out, exp_cfg);
        push(csum, toggle, 0);
        in_valid = extra_valid;
        in_data  = 8'hEE;
        if (good) begin
            exp_cfg = CW'(img % (64'd1 << CW));
            chk("rel_cfg", config_out, exp_cfg);
            chk("rel_fnrst", fabric_nreset, 1);
            chk("rel_fen", fabric_enable, 0);
            chk("rel_ready", in_ready, 0);
            chk("rel_busy", busy, 0);
            tick();
            chk("run_fen", fabric_enable, 1);
            chk("run_done", done, 1);
            chk("run_fnrst", fabric_nreset, 1);
            chk("run_ready", in_ready, 0);
        end else begin
            chk("err_flag", error, 1);
            chk("err_cfg", config_out, exp_cfg);
            chk("err_fnrst", fabric_nreset, 0);
            chk("err_fen", fabric_enable, 0);
            chk("err_done", done, 0);
        end
        in_valid = 0;
    endtask

    initial begin
        logic [WW-1:0] w[NW];
        logic [WW-1:0] x;
        #12;
        chk("rst_ready", in_ready, 0);
        chk("rst_cfg", config_out, 0);
        chk("rst_fnrst", fabric_nreset, 0);
        chk("rst_flags", {busy, done, error, fabric_enable}, 0);
        nreset = 1;
        tick();

        // 6a: valid while idle is ignored, including on the start cycle.
        in_valid = 1; in_data = 8'h77;
        repeat (3) tick();
        chk("idle_ready", in_ready, 0);
        chk("idle_busy", busy, 0);

        // 1: basic load (RELEASE also sees in_valid high)
        w = '{8'h11, 8'h22, 8'h33, 8'h44};
        load(w, 8'h44, 0, 0, 1);
        chk("t1_cfg", config_out, 29'h04332211);

        // 2: bad checksum then recovery
        exp_cfg = 29'h04332211;
        load(w, 8'h45, 0, 0, 0);
        load(w, 8'h44, 0, 0, 0);

        // 3: toggling valid with start mid-load
        load(w, 8'h44, 1, 1, 0);
        chk("t3_cfg", config_out, 29'h04332211);

        // 4: reload from RUN
        w = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        load(w, 8'h00, 0, 0, 0);
        chk("t4_cfg", config_out, 29'h1DCCBBAA);

        // 5: async reset mid-load
        start = 1; tick(); start = 0;
        push(8'h01, 0, 0);
        push(8'h02, 0, 0);
        in_valid = 0;
        #3 nreset = 0;
        #1;
        chk("r5_cfg", config_out, 0);
        chk("r5_ready", in_ready, 0);
        chk("r5_fnrst", fabric_nreset, 0);
        chk("r5_flags", {busy, done, error, fabric_enable}, 0);
        exp_cfg = '0;
        #2 nreset = 1;
        tick();
        w = '{8'h10, 8'h32, 8'h54, 8'h76};
        load(w, 8'h10 ^ 8'h32 ^ 8'h54 ^ 8'h76, 0, 0, 0);
        chk("t5_cfg", config_out, 29'h16543210);

        // random streams
        for (int it = 0; it < 25; it++) begin
            x = '0;
            for (int k = 0; k < NW; k++) begin
                w[k] = WW'($urandom);
                x = x ^ w[k];
            end
            if ($urandom_range(3) == 0) x = x ^ WW'($urandom_range(255, 1));
            load(w, x, bit'($urandom_range(1)), bit'($urandom_range(1)), bit'($urandom_range(1)));
            repeat ($urandom_range(2)) tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1);
    end
endmodule
